// File: rtl/l2_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_wb_pkg
// Purpose  : Shared widths, entry record and FSM encoding for the L2
//            write-back (victim) buffer.
// Revision : 1.0 - initial release
// ============================================================================
package l2_wb_pkg;

    localparam int LINE_W      = 256;
    localparam int OFFSET_W    = 5;
    localparam int LINE_ADDR_W = 27;
    localparam int ADDR_W      = LINE_ADDR_W + OFFSET_W;

    typedef struct packed {
        logic                   valid;
        logic [LINE_ADDR_W-1:0] line_addr;
        logic [LINE_W-1:0]      data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } wb_state_t;

endpackage : l2_wb_pkg
`default_nettype wire

// File: rtl/l2_writeback_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_writeback_buffer_if
// Purpose  : Line-granular read/write/resp bus used both between L2 and the
//            buffer and between the buffer and physical memory.
// Revision : 1.0 - initial release
// ============================================================================
interface l2_writeback_buffer_if;
    import l2_wb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (
        output address, read, write, wdata,
        input  rdata, resp
    );

    modport slave (
        input  address, read, write, wdata,
        output rdata, resp
    );

endinterface : l2_writeback_buffer_if
`default_nettype wire

// File: rtl/l2_wb_store.sv
`default_nettype none
// ============================================================================
// Module   : l2_wb_store
// Purpose  : Circular entry array of evicted lines with address match,
//            push at tail, in-place overwrite of the hit entry and pop at head.
// Revision : 1.0 - initial release
// ============================================================================
module l2_wb_store
    import l2_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_ADDR_W-1:0] i_lookup_addr,
    input  logic [LINE_W-1:0]      i_wr_data,
    input  logic                   i_push,
    input  logic                   i_overwrite,
    input  logic                   i_pop,
    output logic                   o_hit,
    output logic [LINE_W-1:0]      o_hit_data,
    output logic                   o_full,
    output logic [CNT_W-1:0]       o_count,
    output logic [LINE_ADDR_W-1:0] o_head_addr,
    output logic [LINE_W-1:0]      o_head_data
);

    wb_entry_t              r_entries [DEPTH];
    logic [IDX_W-1:0]       r_head;
    logic [IDX_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [DEPTH-1:0]       w_match;
    logic [IDX_W-1:0]       w_hit_idx;
    wb_entry_t              w_push_entry;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] ptr);
        return (ptr == IDX_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
        assign w_match[gi] = r_entries[gi].valid &&
                             (r_entries[gi].line_addr == i_lookup_addr);
    end

    // Coalescing keeps at most one match, so a plain scan is sufficient.
    always_comb begin
        o_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                o_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_push_entry.valid     = 1'b1;
        w_push_entry.line_addr = i_lookup_addr;
        w_push_entry.data      = i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_entries[r_tail] <= w_push_entry;
                r_tail            <= f_next(r_tail);
            end
            if (i_overwrite) begin
                r_entries[w_hit_idx].data <= i_wr_data;
            end
            if (i_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= f_next(r_head);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_hit_data  = r_entries[w_hit_idx].data;
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_count     = r_count;
    assign o_head_addr = r_entries[r_head].line_addr;
    assign o_head_data = r_entries[r_head].data;

endmodule : l2_wb_store
`default_nettype wire

// File: rtl/l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : l2_writeback_buffer
// Purpose  : Victim buffer between L2 and physical memory: fast eviction
//            acknowledge, background drain, read forwarding from pending lines.
// Revision : 1.0 - initial release
// ============================================================================
module l2_writeback_buffer
    import l2_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2_writeback_buffer_if.slave  l2,
    l2_writeback_buffer_if.master pmem
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_state_t              r_state;
    wb_state_t              w_state_next;
    logic [LINE_W-1:0]      r_rdata;
    logic [ADDR_W-1:0]      r_pmem_address;
    logic [LINE_W-1:0]      r_pmem_wdata;

    logic [LINE_ADDR_W-1:0] w_line_addr;
    logic                   w_unused_offset;
    logic                   w_hit;
    logic [LINE_W-1:0]      w_hit_data;
    logic                   w_full;
    logic [CNT_W-1:0]       w_count;
    logic [LINE_ADDR_W-1:0] w_head_addr;
    logic [LINE_W-1:0]      w_head_data;

    logic                   w_push;
    logic                   w_overwrite;
    logic                   w_pop;
    logic                   w_load_hit;
    logic                   w_load_mem;
    logic                   w_issue_read;
    logic                   w_issue_drain;

    assign w_line_addr     = l2.address[ADDR_W-1:OFFSET_W];
    assign w_unused_offset = ^l2.address[OFFSET_W-1:0];

    l2_wb_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lookup_addr (w_line_addr),
        .i_wr_data     (l2.wdata),
        .i_push        (w_push),
        .i_overwrite   (w_overwrite),
        .i_pop         (w_pop),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data),
        .o_full        (w_full),
        .o_count       (w_count),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Requests are only acted on in IDLE, so an ongoing drain always completes.
    always_comb begin
        w_state_next  = r_state;
        w_push        = 1'b0;
        w_overwrite   = 1'b0;
        w_pop         = 1'b0;
        w_load_hit    = 1'b0;
        w_load_mem    = 1'b0;
        w_issue_read  = 1'b0;
        w_issue_drain = 1'b0;
        case (r_state)
            IDLE: begin
                if (l2.read) begin
                    if (w_hit) begin
                        w_load_hit   = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_issue_read = 1'b1;
                        w_state_next = READ;
                    end
                end else if (l2.write) begin
                    if (w_hit) begin
                        w_overwrite  = 1'b1;
                        w_state_next = RESP;
                    end else if (!w_full) begin
                        w_push       = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        // Full: free the head slot, then retry the write.
                        w_issue_drain = 1'b1;
                        w_state_next  = DRAIN;
                    end
                end else if (w_count != '0) begin
                    w_issue_drain = 1'b1;
                    w_state_next  = DRAIN;
                end
            end
            READ: begin
                if (pmem.resp) begin
                    w_load_mem   = 1'b1;
                    w_state_next = RESP;
                end
            end
            DRAIN: begin
                if (pmem.resp) begin
                    w_pop        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Memory-side address/data are captured on entry so outputs never see l2_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata        <= '0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            if (w_load_hit) begin
                r_rdata <= w_hit_data;
            end else if (w_load_mem) begin
                r_rdata <= pmem.rdata;
            end
            if (w_issue_read) begin
                r_pmem_address <= {w_line_addr, {OFFSET_W{1'b0}}};
            end else if (w_issue_drain) begin
                r_pmem_address <= {w_head_addr, {OFFSET_W{1'b0}}};
                r_pmem_wdata   <= w_head_data;
            end
        end
    end

    assign l2.rdata     = r_rdata;
    assign l2.resp      = (r_state == RESP);
    assign pmem.address = r_pmem_address;
    assign pmem.read    = (r_state == READ);
    assign pmem.write   = (r_state == DRAIN);
    assign pmem.wdata   = r_pmem_wdata;

endmodule : l2_writeback_buffer
`default_nettype wire

// File: doc/l2_writeback_buffer.md
Name: l2_writeback_buffer

Overview:
Write-back (victim) buffer between the L2 cache controller's physical-memory port and physical memory. It absorbs dirty 32-byte line evictions from L2 and acknowledges them quickly, then drains them to memory in the background. L2 line reads are forwarded to memory, or served from the buffer when they hit a pending eviction. Upstream it presents the same read/write/resp handshake that L2 uses toward physical memory.

Parameters:
DEPTH, 2, number of buffered evicted lines (>=1; need not be a power of two)

Ports:
clk  in  1  single system clock
rst_n  in  1  reset; asynchronous assert, active-low
l2_address  in  32  L2 line address; bits [4:0] ignored
l2_read  in  1  L2 line read request, held until l2_resp
l2_write  in  1  L2 line write (eviction) request, held until l2_resp
l2_wdata  in  256  eviction line data
l2_rdata  out  256  read line data, valid while l2_resp=1
l2_resp  out  1  one-cycle completion pulse to L2
pmem_address  out  32  memory line address, bits [4:0]=0
pmem_read  out  1  memory read, held until pmem_resp
pmem_write  out  1  memory write, held until pmem_resp
pmem_wdata  out  256  drain line data
pmem_rdata  in  256  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; count, head and tail cleared; all entries invalid; l2_resp, pmem_read and pmem_write =0; pmem_address, pmem_wdata and l2_rdata =0. Reset mid-transaction drops pmem_read/pmem_write immediately and discards pending entries.
- Storage: circular FIFO of DEPTH entries {valid, line_addr[26:0], data[255:0]}. head/tail wrap at DEPTH. count ranges 0..DEPTH.
- Match: an l2_address[31:5] equal to the line_addr of a valid entry. Coalescing guarantees at most one match; the bench asserts this.
- FSM states: IDLE, READ, DRAIN, RESP.
- IDLE, l2_read (has priority over l2_write if both are asserted):
  - Match: latch entry data into the rdata register; go to RESP.
  - No match: go to READ.
- IDLE, l2_write:
  - Match: overwrite that entry's data in place; count unchanged; go to RESP. This also applies when the buffer is full.
  - No match, count<DEPTH: push at tail; go to RESP.
  - No match, full: go to DRAIN. The request stays pending and is retried in IDLE.
- IDLE, no request, count>0: go to DRAIN.
- READ: pmem_read=1, pmem_address={l2_address[31:5],5'b0}. On pmem_resp, latch pmem_rdata into the rdata register; go to RESP. Reads bypass pending drains; this is safe because any matching line was already served from the buffer.
- DRAIN: pmem_write=1, pmem_address={head.line_addr,5'b0}, pmem_wdata=head.data. On pmem_resp, invalidate head, advance head, decrement count; go to IDLE.
- RESP: l2_resp=1 for exactly one cycle; l2_rdata=rdata register (ignored by L2 for writes); go to IDLE.
- Latency:
  - Buffered write or read hit: l2_resp in the cycle after the request is first seen in IDLE.
  - Read miss: l2_resp in the cycle after pmem_resp.
- Outputs are decoded from the registered state and registers only. No combinational path from l2_* or pmem_resp to any output.
- pmem_resp is ignored outside READ and DRAIN.
- A drain in progress is never aborted by a new L2 request; the request waits in IDLE.
- Write then immediate read of the same line returns the newest buffered data.

Decomposition:
- Package l2_wb_pkg:
  - LINE_W=256, OFFSET_W=5, LINE_ADDR_W=27
  - typedef wb_entry_t
  - enum wb_state_t {IDLE, READ, DRAIN, RESP}
- Sub-module l2_wb_store: the entry array, head/tail/count, the match compare (hit flag + index), push, overwrite and pop. The top level holds only the FSM and datapath muxing.

Test Plan:
- Reset: hold rst_n=0 mid-DRAIN -> pmem_write=0 immediately, l2_resp=0, count=0; after release a read of the drained address goes to pmem.
- Write accept/drain: l2_write addr 0x0000_1234, data A -> l2_resp one cycle later for 1 cycle; then pmem_write addr 0x0000_1220, wdata A, held until pmem_resp (delayed 5 cycles); count returns to 0.
- Forwarding: write 0x100 data A with pmem_resp held low; then l2_read 0x104 -> l2_resp with l2_rdata=A; pmem_read never asserted.
- Full/order (DEPTH=2): writes to 0x100 (A) and 0x200 (B) with memory stalled; write to 0x300 (C) gets no l2_resp until the 0x100 drain completes. Pmem write order is 0x100, 0x200, 0x300.
- Coalesce: full buffer {0x100 A, 0x200 B}; write 0x100 data D -> immediate l2_resp; drain order is 0x100/D then 0x200/B; exactly 2 pmem writes.
- Read miss with pending eviction: buffer holds 0x100; l2_read 0x400 -> pmem_read 0x400 issued before any pmem_write; l2_rdata=pmem_rdata (pattern E) one cycle after pmem_resp.
